// File: rtl/philo_pkg.sv
// Shared 2-bit philosopher state codes used by the fork arbiter and its seats.
package philo_pkg;

  typedef logic [1:0] phil_state_t;

  localparam phil_state_t THINKING = 2'd0;
  localparam phil_state_t READING  = 2'd1;
  localparam phil_state_t EATING   = 2'd2;
  localparam phil_state_t HUNGRY   = 2'd3;

endpackage

// File: rtl/fork_seat.sv
// One philosopher seat: THINKING/HUNGRY/EATING state machine.
// With FORK_ARB_TIMEOUT_EN a meal counter and re-arm flag bound each meal to MAX_EAT cycles.
module fork_seat
  import philo_pkg::*;
`ifdef FORK_ARB_TIMEOUT_EN
#(
  parameter int MAX_EAT = 8
)
`endif
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        sel,
  output phil_state_t state,
  output logic        expired
);

`ifdef FORK_ARB_TIMEOUT_EN
  localparam int CW = $clog2(MAX_EAT + 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_inc;
  logic          armed;
  logic          tmo;

  assign cnt_inc = cnt + CW'(1);
  // A withdrawn request wins over timeout, so only a held request is cut off.
  assign tmo     = (state == EATING) && req && (cnt_inc == CW'(MAX_EAT));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= THINKING;
      cnt     <= '0;
      armed   <= 1'b1;
      expired <= 1'b0;
    end else begin
      expired <= tmo;
      if (!req)     armed <= 1'b1;
      else if (tmo) armed <= 1'b0;
      case (state)
        THINKING: if (req && armed) state <= HUNGRY;
        HUNGRY: begin
          if (!req) state <= THINKING;
          else if (sel) begin
            state <= EATING;
            cnt   <= '0;
          end
        end
        EATING: begin
          if (!req || tmo) state <= THINKING;
          else             cnt   <= cnt_inc;
        end
        default: state <= THINKING;
      endcase
    end
  end
`else
  assign expired = 1'b0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= THINKING;
    end else begin
      case (state)
        THINKING: if (req) state <= HUNGRY;
        HUNGRY: begin
          if (!req)     state <= THINKING;
          else if (sel) state <= EATING;
        end
        EATING:  if (!req) state <= THINKING;
        default: state <= THINKING;
      endcase
    end
  end
`endif

endmodule

// File: rtl/fork_arbiter.sv
// Central fork arbiter: round-robin scan granting non-adjacent hungry seats both forks.
// Optional per-meal timeout enabled by defining FORK_ARB_TIMEOUT_EN.
module fork_arbiter
  import philo_pkg::*;
#(
  parameter int N       = 5,
  parameter int MAX_EAT = 8
)(
  input  logic           clk,
  input  logic           reset,
  input  logic [N-1:0]   req,
  output logic [N-1:0]   grant,
  output logic [N-1:0]   forks,
  output logic [2*N-1:0] seat_state,
  output logic [N-1:0]   expired
);

  localparam int PW = $clog2(N);

  logic [N-1:0][1:0] st;
  logic [N-1:0]      elig;
  logic [N-1:0]      sel;
  logic [PW-1:0]     ptr;
  logic [PW-1:0]     first;
  logic              found;

  // Empty marker scope: present only for out-of-range parameters.
  if (N < 3 || MAX_EAT < 1) begin : g_bad_params
  end

  for (genvar i = 0; i < N; i++) begin : g_seat
    fork_seat
`ifdef FORK_ARB_TIMEOUT_EN
      #(.MAX_EAT(MAX_EAT))
`endif
    u_seat (
      .clk     (clk),
      .reset   (reset),
      .req     (req[i]),
      .sel     (sel[i]),
      .state   (st[i]),
      .expired (expired[i])
    );

    assign grant[i]          = (st[i] == EATING);
    assign elig[i]           = (st[i] == HUNGRY) && req[i];
    assign forks[i]          = grant[i] | grant[(i + N - 1) % N];
    assign seat_state[2*i+:2] = st[i];
  end

  // Scan from ptr; a seat is taken only if both neighbours are neither eating nor already taken.
  always_comb begin
    int j, l, r;
    sel   = '0;
    found = 1'b0;
    first = ptr;
    j = 0;
    l = 0;
    r = 0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      l = (j + N - 1) % N;
      r = (j + 1) % N;
      if (elig[j] && !grant[l] && !grant[r] && !sel[l] && !sel[r]) begin
        sel[j] = 1'b1;
        if (!found) begin
          found = 1'b1;
          first = PW'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)     ptr <= '0;
    else if (found) ptr <= (first == PW'(N - 1)) ? '0 : first + PW'(1);
  end

endmodule

// File: tb/tb_fork_arbiter.sv
// Self-checking bench for fork_arbiter: directed scenarios plus randomized requests
// against a seat-level reference model; timeout scenario runs when FORK_ARB_TIMEOUT_EN is defined.
module tb_fork_arbiter;

  localparam int N       = 5;
  localparam int MAX_EAT = 4;
  localparam int TH = 0, EA = 2, HU = 3;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   grant;
  logic [N-1:0]   forks;
  logic [2*N-1:0] seat_state;
  logic [N-1:0]   expired;

  int checks = 0;
  int failures = 0;

  int mst  [N];
  bit marm [N];
  int mlen [N];
  bit mexp [N];
  int mptr;

  fork_arbiter #(.N(N), .MAX_EAT(MAX_EAT)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .grant      (grant),
    .forks      (forks),
    .seat_state (seat_state),
    .expired    (expired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mst[i] = TH; marm[i] = 1'b1; mlen[i] = 0; mexp[i] = 1'b0;
    end
    mptr = 0;
  endtask

  // One clock edge of the table rules: choose diners first, then advance each seat.
  task automatic model_step(input logic [N-1:0] r);
    bit taken [N];
    int nst [N];
    int first;
    int j, lf, rt;
    first = -1;
    for (int i = 0; i < N; i++) taken[i] = 1'b0;
    for (int k = 0; k < N; k++) begin
      j  = (mptr + k) % N;
      lf = (j + N - 1) % N;
      rt = (j + 1) % N;
      if (mst[j] == HU && r[j] && mst[lf] != EA && mst[rt] != EA && !taken[lf] && !taken[rt]) begin
        taken[j] = 1'b1;
        if (first < 0) first = j;
      end
    end
    for (int i = 0; i < N; i++) begin
      nst[i]  = mst[i];
      mexp[i] = 1'b0;
      if (mst[i] == TH && r[i] && marm[i]) nst[i] = HU;
      else if (mst[i] == HU && !r[i]) nst[i] = TH;
      else if (mst[i] == HU && taken[i]) begin nst[i] = EA; mlen[i] = 1; end
      else if (mst[i] == EA && !r[i]) nst[i] = TH;
      else if (mst[i] == EA) begin
`ifdef FORK_ARB_TIMEOUT_EN
        if (mlen[i] >= MAX_EAT) begin
          nst[i] = TH; marm[i] = 1'b0; mexp[i] = 1'b1;
        end else mlen[i]++;
`else
        mlen[i]++;
`endif
      end
      if (!r[i]) marm[i] = 1'b1;
    end
    for (int i = 0; i < N; i++) mst[i] = nst[i];
    if (first >= 0) mptr = (first + 1) % N;
  endtask

  task automatic check_all();
    logic [N-1:0] eg, ef, ee;
    logic [2*N-1:0] es;
    for (int i = 0; i < N; i++) begin
      eg[i] = (mst[i] == EA);
      ee[i] = mexp[i];
      es[2*i+:2] = 2'(mst[i]);
    end
    for (int i = 0; i < N; i++) ef[i] = eg[i] | eg[(i + N - 1) % N];
    chk("grant", 32'(grant), 32'(eg));
    chk("forks", 32'(forks), 32'(ef));
    chk("seat_state", 32'(seat_state), 32'(es));
    chk("expired", 32'(expired), 32'(ee));
    chk("ptr", 32'(dut.ptr), 32'(mptr));
    chk("no_adjacent_grant", 32'(grant & {grant[0], grant[N-1:1]}), 32'd0);
  endtask

  task automatic cycle(input logic [N-1:0] r);
    req = r;
    @(posedge clk);
    if (!reset) model_reset(); else model_step(r);
    @(negedge clk);
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req = '0;
    @(negedge clk);
    model_reset();
    check_all();
    reset = 1'b1;
  endtask

  initial begin
    logic [N-1:0] r;
    model_reset();

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_all();
    chk("reset_state_thinking", 32'(seat_state), 32'd0);
    reset = 1'b1;

    // Single request: HUNGRY after one edge, granted after two
    cycle(5'b00001);
    chk("t2_hungry", 32'(seat_state[1:0]), 32'(HU));
    cycle(5'b00001);
    chk("t2_grant", 32'(grant), 32'b00001);
    chk("t2_forks", 32'(forks), 32'b00011);
    cycle(5'b00000);

    // Everyone at once from ptr=0
    do_reset();
    cycle(5'b11111);
    cycle(5'b11111);
    chk("t3_grant", 32'(grant), 32'b00101);
    chk("t3_ptr", 32'(dut.ptr), 32'd1);
    chk("t3_hungry_134", 32'({seat_state[9:8], seat_state[7:6], seat_state[3:2]}), 32'h3F);
    cycle(5'b00000);

    // Neighbour waits, then inherits the fork
    do_reset();
    cycle(5'b00010);
    cycle(5'b00010);
    chk("t4_seat1_eats", 32'(grant), 32'b00010);
    cycle(5'b00110);
    cycle(5'b00110);
    chk("t4_seat2_blocked", 32'(seat_state[5:4]), 32'(HU));
    cycle(5'b00100);
    chk("t4_seat1_released", 32'(grant[1]), 32'd0);
    cycle(5'b00100);
    chk("t4_seat2_granted", 32'(grant[2]), 32'd1);
    cycle(5'b00000);

`ifdef FORK_ARB_TIMEOUT_EN
    // Meal cut off after MAX_EAT cycles; re-request needs a low-then-high req
    do_reset();
    cycle(5'b01000);
    for (int k = 0; k < MAX_EAT; k++) begin
      cycle(5'b01000);
      chk("t5_grant_held", 32'(grant[3]), 32'd1);
    end
    cycle(5'b01000);
    chk("t5_grant_dropped", 32'(grant[3]), 32'd0);
    chk("t5_expired_pulse", 32'(expired), 32'b01000);
    for (int k = 0; k < 3; k++) begin
      cycle(5'b01000);
      chk("t5_no_regrant", 32'(seat_state[7:6]), 32'(TH));
      chk("t5_expired_low", 32'(expired), 32'd0);
    end
    cycle(5'b00000);
    cycle(5'b01000);
    cycle(5'b01000);
    chk("t5_regrant", 32'(grant[3]), 32'd1);
    cycle(5'b00000);
`endif

    // Asynchronous reset mid-meal
    do_reset();
    cycle(5'b00101);
    cycle(5'b00101);
    chk("t6_both_eat", 32'(grant), 32'b00101);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("t6_async_grant", 32'(grant), 32'd0);
    chk("t6_async_forks", 32'(forks), 32'd0);
    chk("t6_async_state", 32'(seat_state), 32'd0);
    @(negedge clk);
    model_reset();
    check_all();
    reset = 1'b1;
    req = '0;

    // Randomized requests against the model
    do_reset();
    r = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++)
        if ($urandom_range(3) == 0) r[i] = ~r[i];
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
